// File: rtl/axisprbscheck.sv
// -----------------------------------------------------------------------------
// axisprbscheck
//
// AXI-stream sink that checks a stream produced by the PRN generator. It
// self-synchronises to the generator's 31-bit LFSR sequence. Once locked it
// free-runs its own copy of the sequence (a flywheel), compares each accepted
// beat against that copy and keeps saturating beat and error counters.
//
// Ports
//   S_AXI_ACLK     in   clock
//   S_AXI_ARESET   in   asynchronous, active-high reset
//   S_AXIS_TVALID  in   beat valid
//   S_AXIS_TREADY  out  sink ready (1 from the first edge after reset, no backpressure)
//   S_AXIS_TDATA   in   beat data, C_AXIS_DATA_WIDTH bits
//   i_clear        in   synchronous clear of both counters
//   o_locked       out  checker is locked to the sequence
//   o_err          out  one-cycle pulse: a locked beat mismatched
//   o_beat_count   out  beats accepted while locked, saturating
//   o_err_count    out  mismatching locked beats, saturating
// -----------------------------------------------------------------------------
module axisprbscheck #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int LGCOUNT           = 32,
  parameter int LOCK_COUNT        = 8,
  parameter int LOSS_COUNT        = 4
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESET,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                         i_clear,
  output logic                         o_locked,
  output logic                         o_err,
  output logic [LGCOUNT-1:0]           o_beat_count,
  output logic [LGCOUNT-1:0]           o_err_count
);

  localparam int W  = C_AXIS_DATA_WIDTH;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  // The feedback taps sit in the top 31 bits. Any extra low bits are
  // history that is shifted out.
  localparam logic [W-1:0] POLY = W'(31'h00002001) << (W - 31);

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] d);
    return {^(d & POLY), d[W-1:1]};
  endfunction

  // An all-zero LFSR state never advances. Such a word is never a match, so
  // an idle or stuck-at-zero link cannot lock.
  function automatic logic degenerate(input logic [W-1:0] d);
    return d[W-1 -: 31] == '0;
  endfunction

  typedef enum logic {
    S_SEARCH,
    S_LOCKED
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   r_ref, ref_nxt;
  logic           r_have, have_nxt;
  logic [MW-1:0]  r_match_cnt, match_nxt;
  logic [LW-1:0]  r_miss_cnt, miss_nxt;
  logic           r_ready;
  logic           r_err, err_nxt;
  logic           beat_inc, err_inc;
  logic [LGCOUNT-1:0] r_beat_count, r_err_count;

  logic         beat;
  logic [W-1:0] exp_word;
  logic         search_match;
  logic         locked_miss;

  assign beat         = S_AXIS_TVALID && r_ready;
  assign exp_word     = lfsr_next(r_ref);
  assign search_match = r_have && (S_AXIS_TDATA == exp_word) && !degenerate(S_AXIS_TDATA);
  assign locked_miss  = (S_AXIS_TDATA != exp_word);

  // State register plus the reference and control registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values. Blocking here would create order-dependent races.
  // NOTE: every register in this block, including the reference word, is
  // reset. This is only a handful of flops and no memory array, so an
  // asynchronous reset leaves no X in the compare path after reset.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state        <= S_SEARCH;
      r_ref        <= '0;
      r_have       <= 1'b0;
      r_match_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_beat_count <= '0;
      r_err_count  <= '0;
    end else begin
      state       <= state_nxt;
      r_ref       <= ref_nxt;
      r_have      <= have_nxt;
      r_match_cnt <= match_nxt;
      r_miss_cnt  <= miss_nxt;
      r_ready     <= 1'b1;
      r_err       <= err_nxt;

      // A clear takes priority over a simultaneous increment. Both counters
      // stop at all-ones.
      if (i_clear)
        r_beat_count <= '0;
      else if (beat_inc && !(&r_beat_count))
        r_beat_count <= r_beat_count + 1'b1;

      if (i_clear)
        r_err_count <= '0;
      else if (err_inc && !(&r_err_count))
        r_err_count <= r_err_count + 1'b1;
    end
  end

  // Next-state and datapath control.
  // NOTE: every signal this block drives gets a default first. Without the
  // defaults, any path that skips an assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    ref_nxt   = r_ref;
    have_nxt  = r_have;
    match_nxt = r_match_cnt;
    miss_nxt  = r_miss_cnt;
    err_nxt   = 1'b0;
    beat_inc  = 1'b0;
    err_inc   = 1'b0;

    if (beat) begin
      unique case (state)
        S_SEARCH: begin
          // Track the incoming stream word by word until enough
          // consecutive successors line up.
          ref_nxt  = S_AXIS_TDATA;
          have_nxt = 1'b1;
          if (search_match) begin
            if (r_match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_nxt = S_LOCKED;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              match_nxt = r_match_cnt + 1'b1;
            end
          end else begin
            match_nxt = '0;
          end
        end

        S_LOCKED: begin
          // Flywheel: the reference advances on its own and never reloads
          // from the data. One corrupted word therefore counts as exactly
          // one error rather than two.
          ref_nxt  = exp_word;
          beat_inc = 1'b1;
          if (locked_miss) begin
            err_nxt = 1'b1;
            err_inc = 1'b1;
            if (r_miss_cnt == LW'(LOSS_COUNT - 1)) begin
              state_nxt = S_SEARCH;
              ref_nxt   = S_AXIS_TDATA;
              match_nxt = '0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = r_miss_cnt + 1'b1;
            end
          end else begin
            miss_nxt = '0;
          end
        end

        default: state_nxt = S_SEARCH;
      endcase
    end
  end

  assign S_AXIS_TREADY = r_ready;
  assign o_locked      = (state == S_LOCKED);
  assign o_err         = r_err;
  assign o_beat_count  = r_beat_count;
  assign o_err_count   = r_err_count;

endmodule
